// File: rtl/order_book_state_encoder.sv
// order_book_state_encoder: serializes Order Book State messages into a packed 64-bit word stream
// with valid/ready on both sides; a 32-bit residue carries over between messages.
module order_book_state_encoder (
  input  logic         clk,
  input  logic         rst,
  input  logic         msgValid,
  output logic         msgReady,
  input  logic [31:0]  timeStamp,
  input  logic [31:0]  orderBookID,
  input  logic [159:0] stateName,
  input  logic         flush,
  output logic [63:0]  dataOut,
  output logic         dataValid,
  input  logic         dataReady,
  output logic [5:0]   trackerOut,
  output logic         signal_end
);
  typedef enum logic [2:0] {IDLE, W0, W1, W2, W3, FLUSH} state_t;
  state_t state;
  logic [31:0] obReg, residue;
  logic [159:0] snReg;
  logic trk;
  logic xfer;
  assign xfer = dataValid & dataReady;
  assign msgReady = rst & (state == IDLE) & !flush;
  assign signal_end = xfer & (((state == W2) & !trk) | (state == W3));
  assign trackerOut = {trk, 5'd0};
  // trk set means the next message starts at stream offset 32, behind the held residue
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      obReg <= '0;
      snReg <= '0;
      residue <= '0;
      trk <= 1'b0;
      dataOut <= '0;
      dataValid <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (flush & trk) begin
            dataOut <= {32'd0, residue};
            dataValid <= 1'b1;
            state <= FLUSH;
          end else if (msgValid & msgReady) begin
            obReg <= orderBookID;
            snReg <= stateName;
            dataOut <= trk ? {timeStamp, residue} : {orderBookID, timeStamp};
            dataValid <= 1'b1;
            state <= W0;
          end
        W0:
          if (xfer) begin
            dataOut <= trk ? {snReg[31:0], obReg} : snReg[63:0];
            state <= W1;
          end
        W1:
          if (xfer) begin
            dataOut <= trk ? snReg[95:32] : snReg[127:64];
            state <= W2;
          end
        W2:
          if (xfer) begin
            if (trk) begin
              dataOut <= snReg[159:96];
              state <= W3;
            end else begin
              dataValid <= 1'b0;
              residue <= snReg[159:128];
              trk <= 1'b1;
              state <= IDLE;
            end
          end
        W3, FLUSH:
          if (xfer) begin
            dataValid <= 1'b0;
            residue <= '0;
            trk <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
